pwm2raw_capture: RTL and testbench
==================================

// Module: pwm2raw_capture
// PURPOSE
//  Return path for the PWM channel: measures the high time of a PWM input over
//  fixed frames and samples a sign line.
//  Encodes sign+magnitude back into the raw word code (straight, inverted or
//  augmented signed; or unsigned) that the decode path expects.
//  Delivers each encoded word through a valid/ready handshake. Sits between
//  the pad-side PWM/sign inputs and the raw-data consumer.
// PARAMETERS
//  Size   4     raw word width, bits
//  Signed "No"  "Yes": MSB of RawData is sign; "No": all Size bits are magnitude
//  Code   "Str" "Str"/"Inv"/"Aug"; signed encoding. Ignored when Signed=="No"
//  ISize  (localparam) Signed=="No" ? Size : Size-1; magnitude width. Frame length F = 2**ISize clocks
// PORTS
//  Clock    in  1       single clock, rising edge
//  Reset    in  1       synchronous, active-high
//  Enable   in  1       1 = capture frames; 0 = hold frame logic idle
//  PwmIn    in  1       PWM level to measure
//  SignIn   in  1       sign level (1 = negative). Ignored when Signed=="No"
//  RawData  out Size    encoded word, stable while Valid=1
//  Valid    out 1       RawData holds an unconsumed word
//  Ready    in  1       consumer accepts word on cycle with Valid&&Ready
//  Overrun  out 1       sticky: a completed frame was dropped; cleared only by Reset
// BEHAVIOUR
//  Reset: RawData=0, Valid=0, Overrun=0, FrameCnt=0, HighCnt=0, state MEASURE.
//  Reset asserted mid-frame aborts the frame; no partial word is ever emitted.
//  Frame: FrameCnt counts 0..F-1 while Enable=1, wraps to 0.
//   Enable=0: FrameCnt and HighCnt forced to 0, so an Enable rise starts a fresh frame at cycle 0.
//   Enable=0 does not touch Valid/RawData/Overrun.
//  Measure: each enabled cycle with PwmIn=1, HighCnt+1. HighCnt is ISize+1 bits wide.
//   Magnitude M = min(HighCnt,F-1); an all-high frame saturates to F-1.
//  Sign: SignIn is latched on frame cycle 0 and used for that frame.
//  FSM states and transitions:
//   MEASURE: on FrameCnt==F-1, latch M and sign -> ENCODE.
//   ENCODE: one cycle, compute the encoded word -> OUTPUT.
//   OUTPUT: one cycle. If Valid==0 or the current word is accepted this cycle,
//    load RawData and set Valid=1. Otherwise drop the new word and set Overrun=1.
//    Then -> MEASURE.
//  Measurement of the next frame continues during ENCODE/OUTPUT; frames are back-to-back.
//  Latency: Valid rises 2 clocks after the edge ending frame cycle F-1.
//  Handshake: Valid&&Ready clears Valid next cycle unless OUTPUT loads a new word in that same cycle.
//   In that case Valid stays 1 with the new RawData.
//  Encoding (s = sign, M = ISize-bit magnitude):
//   Unsigned: RawData = M.
//   Str: RawData = {s, M}.
//   Inv: s=0 -> {0,M}; s=1 -> {1,~M}. M=0 encodes as all ones.
//   Aug: s=0 -> {0,M}; s=1 -> {1,(2**ISize-M) mod 2**ISize}. M=0 encodes as {1,0..0}.
//  Width rule: all arithmetic is in ISize+1 bits, truncated to ISize, no wider.
// CONFIGURATION
//  PWM2RAW_SYNC_EN defined: PwmIn and SignIn each pass through a 2-flop synchronizer.
//   Synchronizer flops reset to 0.
//   Frame alignment relative to the pins is delayed by 2 clocks; all other timing unchanged.
//  Undefined: PwmIn/SignIn are used directly. The inputs must then already be synchronous to Clock.
// TESTING
//  1 Size=4,Signed=Yes,Code=Str: SignIn=1, PwmIn high 5 of 8 cycles -> RawData=4'b1101, Valid=1 2 clk after frame end.
//  2 Code=Inv: s=1,M=5 -> 4'b1010; s=1,M=0 -> 4'b1111; s=0,M=3 -> 4'b0011.
//  3 Code=Aug: s=1,M=5 -> 4'b1011; s=1,M=0 -> 4'b1000; s=0,M=7 -> 4'b0111.
//  4 Signed=No,Size=4: PwmIn held 1 for whole 16-cycle frame -> RawData=4'b1111 (saturated).
//   PwmIn held 0 -> 4'b0000.
//  5 Ready=0 for two frames (M=2 then M=6) -> RawData stays M=2 word, Overrun=1 after 2nd frame.
//   Then Ready=1 -> Valid drops next cycle; Overrun remains 1.
//  6 Reset pulsed at frame cycle 4, and separately Enable dropped at cycle 4 -> no word from that frame.
//   Next frame starts at cycle 0 and captures correctly.

Source files
------------

// File: rtl/pwm2raw_capture_if.sv
// pwm2raw_capture_if
//   Carries the raw-word handshake between pwm2raw_capture and its consumer.
//   RawData : encoded word, held stable while Valid=1
//   Valid   : RawData holds an unconsumed word
//   Ready   : consumer takes the word on a cycle with Valid && Ready
//   master  : producer side (pwm2raw_capture)
//   slave   : consumer side
interface pwm2raw_capture_if #(
   parameter int Size = 4
);
   logic [Size-1:0] RawData;
   logic            Valid;
   logic            Ready;

   modport master (output RawData, output Valid, input Ready);
   modport slave  (input RawData, input Valid, output Ready);
endinterface

// File: rtl/pwm2raw_capture.sv
// pwm2raw_capture
//   Return path for the PWM channel. Measures the PWM high time over fixed
//   frames of F = 2**ISize clocks and samples a sign line at the start of
//   each frame. It then encodes sign+magnitude into the raw word code that
//   the decode path expects (unsigned, or signed straight/inverted/augmented),
//   and hands each word out through a valid/ready handshake.
//
// Parameters
//   Size   : raw word width
//   Signed : "Yes" -> MSB of RawData is the sign; "No" -> all bits magnitude
//   Code   : "Str" / "Inv" / "Aug" signed encoding (ignored when unsigned)
//
// Ports
//   Clock   : rising-edge clock
//   Reset   : synchronous, active-high
//   Enable  : 1 = capture frames, 0 = frame counters held at 0
//   PwmIn   : PWM level to measure
//   SignIn  : sign level, 1 = negative (ignored when unsigned)
//   Overrun : sticky, a completed frame was dropped; cleared only by Reset
//   raw     : RawData / Valid / Ready handshake (master side)
//
// Configuration macro
//   PWM2RAW_SYNC_EN : when defined, PwmIn and SignIn each pass through a
//                     2-flop synchronizer (frame alignment moves 2 clocks
//                     later relative to the pins). When undefined the
//                     inputs must already be synchronous to Clock.
//
// The encode/output pipeline takes 3 clocks per frame, so frames must be at
// least 4 clocks long (F >= 4).
module pwm2raw_capture #(
   parameter int    Size   = 4,
   parameter string Signed = "No",
   parameter string Code   = "Str"
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Enable,
   input  logic                 PwmIn,
   input  logic                 SignIn,
   output logic                 Overrun,
   pwm2raw_capture_if.master    raw
);

   localparam bit       IsSigned = (Signed == "Yes");
   localparam int       ISize    = IsSigned ? Size - 1 : Size;
   localparam bit [1:0] CodeSel  = (Code == "Inv") ? 2'd1 :
                                   (Code == "Aug") ? 2'd2 : 2'd0;

   // Clamp the (ISize+1)-bit high count to the ISize-bit magnitude range.
   function automatic logic [ISize-1:0] sat_mag(input logic [ISize:0] cnt);
      sat_mag = cnt[ISize] ? {ISize{1'b1}} : cnt[ISize-1:0];
   endfunction

   // Build the raw word from sign and magnitude. The augmented negate is done
   // in ISize+1 bits and truncated, so M=0 maps to magnitude 0.
   function automatic logic [Size-1:0] encode(input logic s, input logic [ISize-1:0] m);
      logic [Size-1:0] w;
      logic [ISize:0]  neg;
      w   = '0;
      neg = {1'b1, {ISize{1'b0}}} - {1'b0, m};
      if (!IsSigned) begin
         w[ISize-1:0] = m;
      end else begin
         w[Size-1] = s;
         case (CodeSel)
            2'd1:    w[ISize-1:0] = s ? ~m : m;
            2'd2:    w[ISize-1:0] = s ? neg[ISize-1:0] : m;
            default: w[ISize-1:0] = m;
         endcase
      end
      encode = w;
   endfunction

   logic pwm_s;
   logic sign_s;

`ifdef PWM2RAW_SYNC_EN
   logic [1:0] pwm_sync;
   logic [1:0] sign_sync;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pwm_sync  <= 2'b00;
         sign_sync <= 2'b00;
      end else begin
         pwm_sync  <= {pwm_sync[0], PwmIn};
         sign_sync <= {sign_sync[0], SignIn};
      end
   end

   assign pwm_s  = pwm_sync[1];
   assign sign_s = sign_sync[1];
`else
   assign pwm_s  = PwmIn;
   assign sign_s = SignIn;
`endif

   // ---- frame measurement ----
   logic [ISize-1:0] frame_cnt;
   logic [ISize:0]   high_cnt;
   logic [ISize:0]   high_sum;
   logic             sign_frame;
   logic             frame_end;

   // high_sum includes the current cycle so the last frame cycle is counted.
   assign high_sum  = high_cnt + {{ISize{1'b0}}, pwm_s};
   assign frame_end = Enable && (&frame_cnt);

   always_ff @(posedge Clock) begin
      if (Reset || !Enable) begin
         frame_cnt <= '0;
         high_cnt  <= '0;
      end else begin
         frame_cnt <= frame_cnt + 1'b1;
         high_cnt  <= frame_end ? '0 : high_sum;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sign_frame <= 1'b0;
      end else if (Enable && (frame_cnt == '0)) begin
         sign_frame <= sign_s;
      end
   end

   // ---- latch / encode / output ----
   typedef enum logic [1:0] {MEASURE, ENCODE, OUTPUT} state_t;

   state_t           state;
   logic [ISize-1:0] mag_p0;
   logic             sign_p0;
   logic [Size-1:0]  word_p1;
   logic [Size-1:0]  raw_q;
   logic             vld_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= MEASURE;
         mag_p0  <= '0;
         sign_p0 <= 1'b0;
         word_p1 <= '0;
         raw_q   <= '0;
         vld_q   <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         // A taken word clears Valid unless OUTPUT reloads it below.
         if (vld_q && raw.Ready) begin
            vld_q <= 1'b0;
         end
         case (state)
            MEASURE: begin
               if (frame_end) begin
                  mag_p0  <= sat_mag(high_sum);
                  sign_p0 <= sign_frame;
                  state   <= ENCODE;
               end
            end
            ENCODE: begin
               word_p1 <= encode(sign_p0, mag_p0);
               state   <= OUTPUT;
            end
            OUTPUT: begin
               if (!vld_q || raw.Ready) begin
                  raw_q <= word_p1;
                  vld_q <= 1'b1;
               end else begin
                  Overrun <= 1'b1;
               end
               state <= MEASURE;
            end
            default: state <= MEASURE;
         endcase
      end
   end

   assign raw.RawData = raw_q;
   assign raw.Valid   = vld_q;

endmodule

// File: tb/tb_pwm2raw_capture.sv
module tb_pwm2raw_capture;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic Reset, Enable, PwmIn, SignIn, Ready;

   pwm2raw_capture_if #(.Size(4)) if_str();
   pwm2raw_capture_if #(.Size(4)) if_inv();
   pwm2raw_capture_if #(.Size(4)) if_aug();
   pwm2raw_capture_if #(.Size(4)) if_uns();

   assign if_str.Ready = Ready;
   assign if_inv.Ready = Ready;
   assign if_aug.Ready = Ready;
   assign if_uns.Ready = Ready;

   logic [3:0] ovr_o;
   logic [3:0] raw_o [4];
   logic [3:0] vld_o;

   assign raw_o[0] = if_str.RawData;  assign vld_o[0] = if_str.Valid;
   assign raw_o[1] = if_inv.RawData;  assign vld_o[1] = if_inv.Valid;
   assign raw_o[2] = if_aug.RawData;  assign vld_o[2] = if_aug.Valid;
   assign raw_o[3] = if_uns.RawData;  assign vld_o[3] = if_uns.Valid;

   pwm2raw_capture #(.Size(4), .Signed("Yes"), .Code("Str")) dut_str (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .PwmIn(PwmIn),
      .SignIn(SignIn), .Overrun(ovr_o[0]), .raw(if_str));
   pwm2raw_capture #(.Size(4), .Signed("Yes"), .Code("Inv")) dut_inv (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .PwmIn(PwmIn),
      .SignIn(SignIn), .Overrun(ovr_o[1]), .raw(if_inv));
   pwm2raw_capture #(.Size(4), .Signed("Yes"), .Code("Aug")) dut_aug (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .PwmIn(PwmIn),
      .SignIn(SignIn), .Overrun(ovr_o[2]), .raw(if_aug));
   pwm2raw_capture #(.Size(4), .Signed("No"), .Code("Str")) dut_uns (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .PwmIn(PwmIn),
      .SignIn(SignIn), .Overrun(ovr_o[3]), .raw(if_uns));

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: per channel, frame position and high count in plain
   // integers, words computed arithmetically and delivered two clocks after
   // the frame ends through a two-slot delay line.
   int m_fcnt [4];
   int m_hcnt [4];
   int m_sgn  [4];
   int m_vld  [4];
   int m_raw  [4];
   int m_ovr  [4];
   int d1v [4], d1w [4], d2v [4], d2w [4];

   function automatic int frame_len(input int c);
      return (c == 3) ? 16 : 8;
   endfunction

   function automatic int ref_word(input int c, input int s, input int m);
      case (c)
         0: return s ? 8 + m : m;
         1: return s ? 8 + (7 - m) : m;
         2: return s ? 8 + ((8 - m) % 8) : m;
         default: return m;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit p, input bit s, input bit rd);
      for (int c = 0; c < 4; c++) begin
         if (r) begin
            m_fcnt[c] = 0; m_hcnt[c] = 0; m_sgn[c] = 0;
            m_vld[c] = 0; m_raw[c] = 0; m_ovr[c] = 0;
            d1v[c] = 0; d1w[c] = 0; d2v[c] = 0; d2w[c] = 0;
         end else begin
            int f, ones, m;
            bit acc;
            f   = frame_len(c);
            acc = (m_vld[c] != 0) && rd;
            if (d2v[c] != 0) begin
               if (m_vld[c] == 0 || acc) begin
                  m_raw[c] = d2w[c];
                  m_vld[c] = 1;
               end else begin
                  m_ovr[c] = 1;
               end
            end else if (acc) begin
               m_vld[c] = 0;
            end
            d2v[c] = d1v[c]; d2w[c] = d1w[c];
            d1v[c] = 0;
            if (e) begin
               if (m_fcnt[c] == 0) m_sgn[c] = s;
               ones = m_hcnt[c] + p;
               if (m_fcnt[c] == f - 1) begin
                  m = (ones > f - 1) ? f - 1 : ones;
                  d1v[c] = 1;
                  d1w[c] = ref_word(c, m_sgn[c], m);
                  m_fcnt[c] = 0;
                  m_hcnt[c] = 0;
               end else begin
                  m_fcnt[c] = m_fcnt[c] + 1;
                  m_hcnt[c] = ones;
               end
            end else begin
               m_fcnt[c] = 0;
               m_hcnt[c] = 0;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit p, input bit s, input bit rd);
      Reset = r; Enable = e; PwmIn = p; SignIn = s; Ready = rd;
      @(posedge Clock);
      model_edge(r, e, p, s, rd);
      #1;
      for (int c = 0; c < 4; c++) begin
         check_val($sformatf("valid%0d", c), vld_o[c], m_vld[c]);
         check_val($sformatf("raw%0d", c), raw_o[c], m_raw[c]);
         check_val($sformatf("ovr%0d", c), ovr_o[c], m_ovr[c]);
      end
   endtask

   task automatic run_frame(input bit s, input logic [15:0] pat, input int len, input bit rd);
      for (int i = 0; i < len; i++) step(1'b0, 1'b1, pat[i], s, rd);
   endtask

   task automatic idle2(input bit rd);
      step(1'b0, 1'b0, 1'b0, 1'b0, rd);
      step(1'b0, 1'b0, 1'b0, 1'b0, rd);
   endtask

   initial begin
      Reset = 1'b1; Enable = 1'b0; PwmIn = 1'b0; SignIn = 1'b0; Ready = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("rst_valid", vld_o, 4'b0000);
      check_val("rst_ovr", ovr_o, 4'b0000);

      // s=1, 5 of 8 high; Valid appears exactly 2 clocks after frame end
      run_frame(1'b1, 16'h006B, 8, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("lat_not_yet", vld_o[0], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("lat_valid", vld_o[0], 1'b1);
      check_val("str_s1m5", raw_o[0], 4'b1101);
      check_val("inv_s1m5", raw_o[1], 4'b1010);
      check_val("aug_s1m5", raw_o[2], 4'b1011);

      // s=1, M=0
      run_frame(1'b1, 16'h0000, 8, 1'b1);
      idle2(1'b0);
      check_val("inv_s1m0", raw_o[1], 4'b1111);
      check_val("aug_s1m0", raw_o[2], 4'b1000);
      check_val("str_s1m0", raw_o[0], 4'b1000);

      // s=0, all-high frame saturates to 7
      run_frame(1'b0, 16'h00FF, 8, 1'b1);
      idle2(1'b0);
      check_val("aug_s0m7", raw_o[2], 4'b0111);
      check_val("str_s0m7", raw_o[0], 4'b0111);

      // s=0, M=3
      run_frame(1'b0, 16'h0007, 8, 1'b1);
      idle2(1'b0);
      check_val("inv_s0m3", raw_o[1], 4'b0011);

      // unsigned 16-cycle frames: all high then all low
      run_frame(1'b0, 16'hFFFF, 16, 1'b1);
      idle2(1'b0);
      check_val("uns_sat", raw_o[3], 4'b1111);
      run_frame(1'b0, 16'h0000, 16, 1'b1);
      idle2(1'b0);
      check_val("uns_zero", raw_o[3], 4'b0000);

      // overrun: two frames with Ready low
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 16'h0003, 8, 1'b0);
      run_frame(1'b0, 16'h003F, 8, 1'b0);
      idle2(1'b0);
      check_val("ovr_keep_word", raw_o[0], 4'b0010);
      check_val("ovr_set", ovr_o[0], 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("ovr_drain", vld_o[0], 1'b0);
      check_val("ovr_sticky", ovr_o[0], 1'b1);

      // Reset at frame cycle 4 aborts the frame; next frame is fresh
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check_val("rst_mid_ovr", ovr_o[0], 1'b0);
      run_frame(1'b1, 16'h001F, 8, 1'b1);
      check_val("rst_mid_noword", vld_o[0], 1'b0);
      idle2(1'b0);
      check_val("rst_mid_next", raw_o[0], 4'b1101);

      // Enable dropped at frame cycle 4
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_frame(1'b0, 16'h000F, 8, 1'b1);
      check_val("en_drop_noword", vld_o[0], 1'b0);
      idle2(1'b0);
      check_val("en_drop_next", raw_o[0], 4'b0100);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 249) == 0, $urandom_range(0, 9) != 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              (i % 300) < 40 ? 1'b0 : ($urandom_range(0, 9) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
